key_event_gen: RTL

Front-end conditioner for the board push-buttons, on the input side of the time-set, stopwatch, timer and alarm controls. It converts raw active-low KEY levels into clean events:
- synchronized and debounced level
- single-cycle press and release strobes
- auto-repeating "step" strobes for hold-to-increment

It replaces level-sensitive key use, so that one press advances a setting by exactly one and a held key scrolls at a fixed rate.

---
 rtl/key_event_gen_pkg.sv | 27 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/key_event_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/key_event_gen_pkg.sv
// Shared definitions for the push-button event generator:
// repeat FSM state encodings, 50 MHz default timing and width helpers.
package key_event_gen_pkg;

    // Per-key repeat FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Default timing for a 50 MHz CLOCK_50
    localparam int DEF_N_KEYS              = 3;
    localparam int DEF_DEBOUNCE_CYCLES     = 500_000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25_000_000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 5_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer plus debounce counter.
// Ports: clk, rst (async, active-high), key_n (raw, active-low),
//        level (debounced, 1 = pressed).
module key_debounce
    import key_event_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          synced;
    logic          stable;
    logic [CW-1:0] count;

    // Synchronizer presets to the released (high) level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    assign synced = ~sync_b;

    // Any return to the current stable level restarts the count,
    // so a glitch shorter than DEBOUNCE_CYCLES leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (synced == stable) begin
            count  <= '0;
        end else if (count == LAST) begin
            stable <= synced;
            count  <= '0;
        end else begin
            count  <= count + 1'b1;
        end
    end

    assign level = stable;

endmodule

// File: rtl/key_event_gen.sv
// Converts raw active-low KEY levels into debounced level, press and
// release strobes, and auto-repeating step strobes, one lane per key.
// Ports: CLOCK_50, reset (async, active-high), key_n[N_KEYS] raw keys;
//        held, press_pulse, release_pulse, step_pulse, long_press.
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int N_KEYS              = DEF_N_KEYS,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] step_pulse,
    output logic [N_KEYS-1:0] long_press
);

    localparam int RW = cnt_width(
        max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key

        logic          level;
        rep_state_e    state;
        rep_state_e    state_nxt;
        logic [RW-1:0] cnt;
        logic [RW-1:0] cnt_nxt;
        logic          press_nxt;
        logic          release_nxt;
        logic          step_nxt;
        logic          long_nxt;
        logic          press_q;
        logic          release_q;
        logic          step_q;
        logic          long_q;

        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (CLOCK_50),
            .rst  (reset),
            .key_n(key_n[i]),
            .level(level)
        );

        // State register
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next state; counter clears on every state change and
        // wraps on each repeat step, so it can never overflow.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (level) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (!level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == DELAY_LAST) begin
                        state_nxt = REPEAT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!level) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == RATE_LAST) begin
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Outputs decoded from the transition being taken; a release
        // masks any step that would otherwise be due this cycle.
        always_comb begin
            press_nxt   = (state == IDLE) && level;
            release_nxt = (state != IDLE) && !level;
            long_nxt    = (state == WAIT) && level
                          && (cnt == DELAY_LAST);
            step_nxt    = press_nxt || long_nxt
                          || ((state == REPEAT) && level
                              && (cnt == RATE_LAST));
        end

        // Registered strobes
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= press_nxt;
                release_q <= release_nxt;
                step_q    <= step_nxt;
                long_q    <= long_nxt;
            end
        end

        assign held[i]          = level;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign step_pulse[i]    = step_q;
        assign long_press[i]    = long_q;

    end

endmodule
